// File: rtl/conv_8_32.sv
// Byte-to-word deserializer for the PHY receive path: assembles four valid bytes,
// MSB byte first, into a registered 32-bit word and flags streams that break mid-word.
module conv_8_32 (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic        valid_in,
  input  logic [7:0]  data_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        align_err
);

  // Byte counter: names say which byte of the word the next valid input fills.
  typedef enum logic [1:0] {
    CNT_B3 = 2'd0,  // expect [31:24]
    CNT_B2 = 2'd1,  // expect [23:16]
    CNT_B1 = 2'd2,  // expect [15:8]
    CNT_B0 = 2'd3   // expect [7:0]
  } cnt_e;

  cnt_e        cnt, cnt_nxt;
  logic [23:0] asm_r, asm_nxt;
  logic [31:0] data_nxt;
  logic        valid_nxt, err_nxt;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    cnt_nxt   = cnt;
    asm_nxt   = asm_r;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;

    if (valid_in) begin
      case (cnt)
        CNT_B3: begin
          asm_nxt[23:16] = data_in;
          cnt_nxt        = CNT_B2;
        end
        CNT_B2: begin
          asm_nxt[15:8] = data_in;
          cnt_nxt       = CNT_B1;
        end
        CNT_B1: begin
          asm_nxt[7:0] = data_in;
          cnt_nxt      = CNT_B0;
        end
        CNT_B0: begin
          // Wrap straight to the first byte so back-to-back words need no gap.
          data_nxt  = {asm_r, data_in};
          valid_nxt = 1'b1;
          cnt_nxt   = CNT_B3;
        end
      endcase
    end else if (cnt != CNT_B3) begin
      // Stream broke mid-word: drop the partial word; the stale asm bytes are
      // always overwritten before they can reach data_out.
      err_nxt = 1'b1;
      cnt_nxt = CNT_B3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; all of it is plain flops, so everything gets an async reset.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      cnt       <= CNT_B3;
      asm_r     <= 24'h0;
      data_out  <= 32'h0;
      valid_out <= 1'b0;
      align_err <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      asm_r     <= asm_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      align_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_conv_8_32.sv
// Directed self-checking bench for conv_8_32: word assembly, gaps, alignment errors,
// asynchronous reset and a loopback from a modelled 32-to-8 serializer.
module tb_conv_8_32;

  logic        clk_4f;
  logic        reset_L;
  logic        valid_in;
  logic [7:0]  data_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        align_err;

  int checks = 0;
  int errors = 0;

  conv_8_32 dut (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .align_err (align_err)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of input on the falling edge, then settle just after the rising edge.
  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk_4f);
    valid_in = v;
    data_in  = d;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'hxx);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] d, input logic v, input logic e);
    check({tag, ".data"}, data_out, d);
    check({tag, ".valid"}, {31'b0, valid_out}, {31'b0, v});
    check({tag, ".err"}, {31'b0, align_err}, {31'b0, e});
  endtask

  // Send a full word MSB byte first, as the 32-to-8 converter would, checking each edge.
  task automatic send_word(input string tag, input logic [31:0] w, input logic [31:0] prev);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w[31-8*i -: 8]);
      if (i < 3) expect_out(tag, prev, 1'b0, 1'b0);
      else       expect_out(tag, w, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    #1;
    expect_out("reset", 32'h0, 1'b0, 1'b0);
    @(posedge clk_4f); #1;
    expect_out("reset_clk", 32'h0, 1'b0, 1'b0);
    @(negedge clk_4f);
    reset_L = 1'b1;

    // Basic word AA BB CC DD, then a legal gap between words.
    send_word("aabbccdd", 32'hAABBCCDD, 32'h0);
    idle();
    expect_out("gap_cnt0", 32'hAABBCCDD, 1'b0, 1'b0);

    // Eight back-to-back bytes 01..08: pulses on edges 4 and 8 only.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i));
      if (i < 4)       expect_out("b2b", 32'hAABBCCDD, 1'b0, 1'b0);
      else if (i == 4) expect_out("b2b_w1", 32'h01020304, 1'b1, 1'b0);
      else if (i < 8)  expect_out("b2b", 32'h01020304, 1'b0, 1'b0);
      else             expect_out("b2b_w2", 32'h05060708, 1'b1, 1'b0);
    end

    // 11 22 then a gap: one alignment error, partial word never emitted.
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    expect_out("part2", 32'h05060708, 1'b0, 1'b0);
    idle();
    expect_out("drop_cnt2", 32'h05060708, 1'b0, 1'b1);
    send_word("33445566", 32'h33445566, 32'h05060708);

    // Drop with three bytes collected.
    step(1'b1, 8'hA1);
    step(1'b1, 8'hA2);
    step(1'b1, 8'hA3);
    idle();
    expect_out("drop_cnt3", 32'h33445566, 1'b0, 1'b1);
    idle();
    expect_out("err_pulse", 32'h33445566, 1'b0, 1'b0);

    // Drop with one byte collected.
    step(1'b1, 8'hB1);
    idle();
    expect_out("drop_cnt1", 32'h33445566, 1'b0, 1'b1);

    // 12 34 56 then an asynchronous reset between edges.
    step(1'b1, 8'h12);
    step(1'b1, 8'h34);
    step(1'b1, 8'h56);
    #2;
    reset_L = 1'b0;
    #1;
    expect_out("async_rst", 32'h0, 1'b0, 1'b0);
    @(negedge clk_4f);
    valid_in = 1'b1;
    data_in  = 8'h77;
    @(posedge clk_4f); #1;
    expect_out("rst_hold", 32'h0, 1'b0, 1'b0);
    @(negedge clk_4f);
    reset_L  = 1'b1;
    valid_in = 1'b0;
    send_word("9abcdef0", 32'h9ABCDEF0, 32'h0);

    // All-zero word is legal and pulses valid_out.
    send_word("zero", 32'h0, 32'h9ABCDEF0);
    idle();
    expect_out("zero_after", 32'h0, 1'b0, 1'b0);

    // Loopback from the serializer model, back-to-back words.
    send_word("lb_deadbeef", 32'hDEADBEEF, 32'h0);
    send_word("lb_01234567", 32'h01234567, 32'hDEADBEEF);
    idle();
    expect_out("lb_end", 32'h01234567, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
